// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, issues one-outstanding
// requests to instruction memory, buffers returned words in a small FIFO
// and flushes everything on a jump/branch redirect.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } fetchState_t;

  fetchState_t   state, stateNext;
  logic [31:0]   fetchPc;
  logic [31:0]   discardAddr;
  logic [31:0]   redirectAligned;
  logic [31:0]   fifoData [DEPTH];
  logic [31:0]   fifoPc   [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [CW-1:0] count, countNext;
  logic          push, pop, space;

  assign redirectAligned = redirect_pc & 32'hFFFF_FFFC;

  // A redirect kills any same-cycle push or pop, so both are gated by it.
  assign push      = (state == REQ) && imem_ack && !redirect_valid;
  assign pop       = inst_valid && inst_ready && !redirect_valid;
  assign countNext = count + CW'(push) - CW'(pop);
  assign space     = countNext < CW'(DEPTH);

  // Request is held steady through DISCARD using the address latched when the redirect hit.
  assign imem_req    = (state == REQ) || (state == DISCARD);
  assign imem_addr   = (state == DISCARD) ? discardAddr : fetchPc;
  assign inst_valid  = (count != '0);
  assign instruction = inst_valid ? fifoData[rdPtr] : 32'h0;
  assign inst_pc     = inst_valid ? fifoPc[rdPtr]   : 32'h0;

  // Fetch state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Next-state logic: redirect outranks ack, and a full queue parks the fetcher in IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (!redirect_valid && space) stateNext = REQ;
      end
      REQ: begin
        if (redirect_valid)  stateNext = imem_ack ? IDLE : DISCARD;
        else if (imem_ack)   stateNext = space ? REQ : IDLE;
      end
      DISCARD: begin
        if (imem_ack) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Fetch PC and the abandoned address that must stay on the bus until memory acks it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetchPc     <= RESET_PC;
      discardAddr <= 32'h0;
    end else begin
      if (state == REQ && redirect_valid && !imem_ack) discardAddr <= fetchPc;
      if (redirect_valid)  fetchPc <= redirectAligned;
      else if (push)       fetchPc <= fetchPc + 32'd4;
    end
  end

  // FIFO bookkeeping; a redirect empties the queue outright.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop)  rdPtr <= rdPtr + PW'(1);
      count <= countNext;
    end
  end

  // FIFO storage needs no reset because outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoData[wrPtr] <= imem_rdata;
      fifoPc[wrPtr]   <= fetchPc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  int vectors = 0;
  int miscompares = 0;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  assign imem_rdata = memWord(imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Hold reset two cycles, release between edges, then advance into the first REQ cycle.
  task automatic doReset();
    rst = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(); step();
    chk("reset_req",   32'(imem_req),   32'h0);
    chk("reset_valid", 32'(inst_valid), 32'h0);
    chk("reset_instr", instruction,     32'h0);
    chk("reset_pc",    inst_pc,         32'h0);
    rst = 1'b1;
    step();
    chk("reset_first_req",  32'(imem_req), 32'h1);
    chk("reset_first_addr", imem_addr,     32'h0000_3000);
  endtask

  task automatic test_stream();
    doReset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("stream_addr", imem_addr, 32'h3000 + 32'(4 * i));
      chk("stream_valid", 32'(inst_valid), (i > 0) ? 32'h1 : 32'h0);
      if (i > 0) begin
        chk("stream_pc",    inst_pc,     32'h3000 + 32'(4 * (i - 1)));
        chk("stream_instr", instruction, memWord(32'h3000 + 32'(4 * (i - 1))));
      end
      step();
    end
    imem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int accepted;
    doReset();
    imem_ack = 1'b1; inst_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      if (imem_req) accepted++;
      step();
    end
    chk("bp_accepted", 32'(accepted),   32'd4);
    chk("bp_req_off",  32'(imem_req),   32'h0);
    chk("bp_head",     inst_pc,         32'h0000_3000);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0; imem_ack = 1'b0;
    chk("bp_req_again", 32'(imem_req), 32'h1);
    chk("bp_addr",      imem_addr,     32'h0000_3010);
    chk("bp_head_next", inst_pc,       32'h0000_3004);
  endtask

  task automatic test_latency();
    doReset();
    inst_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 4; w++) begin
        imem_ack = (w == 3);
        chk("lat_req",  32'(imem_req), 32'h1);
        chk("lat_addr", imem_addr,     32'h3000 + 32'(4 * k));
        if (k > 0 && w == 0) begin
          chk("lat_valid", 32'(inst_valid), 32'h1);
          chk("lat_pc",    inst_pc,         32'h3000 + 32'(4 * (k - 1)));
        end
        if (k > 0 && w == 1) chk("lat_drained", 32'(inst_valid), 32'h0);
        step();
      end
    end
    imem_ack = 1'b0; inst_ready = 1'b0;
  endtask

  task automatic test_redirect_discard();
    doReset();
    imem_ack = 1'b1; inst_ready = 1'b0;
    step(); step(); step();
    chk("rd_fill_pc",   inst_pc,   32'h0000_3000);
    chk("rd_fill_addr", imem_addr, 32'h0000_300C);
    imem_ack = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3400;
    step();
    redirect_valid = 1'b0;
    chk("rd_flush_valid", 32'(inst_valid), 32'h0);
    chk("rd_discard_req", 32'(imem_req),   32'h1);
    chk("rd_discard_addr", imem_addr,      32'h0000_300C);
    step();
    chk("rd_hold_addr", imem_addr, 32'h0000_300C);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("rd_idle_req",   32'(imem_req),   32'h0);
    chk("rd_idle_valid", 32'(inst_valid), 32'h0);
    step();
    chk("rd_new_addr", imem_addr, 32'h0000_3400);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("rd_first_pc",    inst_pc,     32'h0000_3400);
    chk("rd_first_instr", instruction, memWord(32'h0000_3400));
  endtask

  task automatic test_redirect_ack();
    doReset();
    imem_ack = 1'b1; inst_ready = 1'b1;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3402;
    step();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    chk("ra_valid", 32'(inst_valid), 32'h0);
    chk("ra_req",   32'(imem_req),   32'h0);
    chk("ra_instr", instruction,     32'h0);
    step();
    chk("ra_addr", imem_addr, 32'h0000_3400);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("ra_pc", inst_pc, 32'h0000_3400);
  endtask

  task automatic test_wrap_and_reset();
    doReset();
    inst_ready = 1'b1; imem_ack = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    chk("wr_discard_addr", imem_addr, 32'h0000_3000);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    step();
    chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    imem_ack = 1'b1;
    step();
    chk("wr_pc_top",   inst_pc,   32'hFFFF_FFFC);
    chk("wr_addr_low", imem_addr, 32'h0000_0000);
    step();
    chk("wr_pc_low", inst_pc, 32'h0000_0000);
    imem_ack = 1'b0; inst_ready = 1'b0;
    chk("wr_req_before_rst", 32'(imem_req), 32'h1);
    rst = 1'b0;
    #1;
    chk("wr_async_req",   32'(imem_req),   32'h0);
    chk("wr_async_valid", 32'(inst_valid), 32'h0);
    step(); step();
    rst = 1'b1;
    step();
    chk("wr_restart_req",  32'(imem_req), 32'h1);
    chk("wr_restart_addr", imem_addr,     32'h0000_3000);
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_redirect_discard();
    test_redirect_ack();
    test_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
